piso_tx_arbiter: RTL and testbench

- Shares one parallel-in/serial-out shift path between two requesters.
- Arbitrates round-robin between requester 0 and requester 1, and accepts a WIDTH-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, with frame-qualifier strobes, then enforces a programmable idle gap before the next word.
- Sits between word-producing blocks and a single serial line.

---
 rtl/piso_tx_arbiter_if.sv | 42 ++++
 rtl/piso_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_piso_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_arbiter_if
// Purpose  : Bundles the two requester handshakes and the serial frame
//            outputs of piso_tx_arbiter.
// Signals  : req0_valid/req0_data/req0_ready - requester 0 handshake
//            req1_valid/req1_data/req1_ready - requester 1 handshake
//            s_out/s_valid/s_start/s_last    - serial line and frame strobes
//            grant_id                        - owner of the current frame
//            busy                            - arbiter not idle
// Modports : master - requester/line side; slave - the arbiter itself
// Revision : 1.0 - initial release
// ============================================================================
interface piso_tx_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             s_out;
    logic             s_valid;
    logic             s_start;
    logic             s_last;
    logic             grant_id;
    logic             busy;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, s_out, s_valid, s_start, s_last,
               grant_id, busy
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, s_out, s_valid, s_start, s_last,
               grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : piso_tx_arbiter
// Purpose  : Round-robin arbiter between two word producers feeding a single
//            parallel-in/serial-out shifter. A granted word is shifted out
//            MSB-first with start/last strobes, followed by GAP idle cycles.
// Ports    : clk     - rising-edge clock
//            reset_n - asynchronous active-low reset
//            bus     - piso_tx_arbiter_if.slave (handshakes + serial outputs)
// Revision : 1.0 - initial release
// ============================================================================
module piso_tx_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    piso_tx_arbiter_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bit_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_ptr;      // last granted requester
    logic             r_grant;
    logic             r_s_out;
    logic             r_s_valid;
    logic             r_s_start;
    logic             r_s_last;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic [GW-1:0]    w_gap_cnt_nxt;
    logic             w_idle;
    logic             w_pick1;
    logic             w_accept;
    logic             w_s_out_nxt;
    logic             w_s_valid_nxt;
    logic             w_s_start_nxt;
    logic             w_s_last_nxt;
    logic             w_busy_nxt;

    // Requester 1 wins when it is alone, or when both ask and requester 0
    // was granted last. Gating readies with reset_n keeps them 0 in reset.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_pick1  = bus.req1_valid & (~bus.req0_valid | ~r_ptr);
    assign w_accept = w_idle & (bus.req0_valid | bus.req1_valid);

    assign bus.req0_ready = reset_n & w_idle & bus.req0_valid & ~w_pick1;
    assign bus.req1_ready = reset_n & w_idle & w_pick1;

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_ptr     <= 1'b1;
            r_grant   <= 1'b0;
            r_s_out   <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_start <= 1'b0;
            r_s_last  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            if (w_accept) begin
                r_ptr   <= w_pick1;
                r_grant <= w_pick1;
            end
            r_s_out   <= w_s_out_nxt;
            r_s_valid <= w_s_valid_nxt;
            r_s_start <= w_s_start_nxt;
            r_s_last  <= w_s_last_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shreg_nxt   = w_pick1 ? bus.req1_data : bus.req0_data;
                    w_bit_cnt_nxt = CW'(WIDTH - 1);
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                if (r_bit_cnt == '0) begin
                    if (GAP > 0) begin
                        w_state_nxt   = ST_GAP;
                        w_gap_cnt_nxt = GW'(GAP - 1);
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt - CW'(1);
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - GW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: outputs are registered, so they are derived from the
    // next-state values and appear one cycle after the deciding edge.
    always_comb begin
        w_s_valid_nxt = (w_state_nxt == ST_SHIFT);
        w_s_out_nxt   = w_s_valid_nxt & w_shreg_nxt[WIDTH-1];
        w_s_start_nxt = w_accept;
        w_s_last_nxt  = w_s_valid_nxt & (w_bit_cnt_nxt == '0);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    assign bus.s_out    = r_s_out;
    assign bus.s_valid  = r_s_valid;
    assign bus.s_start  = r_s_start;
    assign bus.s_last   = r_s_last;
    assign bus.grant_id = r_grant;
    assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_tx_arbiter
// Purpose  : Self-checking bench for piso_tx_arbiter. Unit a uses GAP=1,
//            unit b uses GAP=0. A timeline model predicts every output from
//            the cycle of the last acceptance and the word taken.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_tx_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;

    piso_tx_arbiter_if #(.WIDTH(W)) bus_a ();
    piso_tx_arbiter_if #(.WIDTH(W)) bus_b ();

    piso_tx_arbiter #(.WIDTH(W), .GAP(1)) dut_a (
        .clk     (clk),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    piso_tx_arbiter #(.WIDTH(W), .GAP(0)) dut_b (
        .clk     (clk),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Timeline model state per unit
    int         m_has[2];
    int         m_acc[2];
    int         m_ptr[2];
    logic       m_grant[2];
    logic [W-1:0] m_word[2];
    int         gapv[2];
    logic       acc_now[2];
    int         qc_a[$];
    int         qg_a[$];
    int         qc_b[$];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int u);
        m_has[u]   = 0;
        m_acc[u]   = 0;
        m_ptr[u]   = 1;
        m_grant[u] = 1'b0;
        m_word[u]  = '0;
    endtask

    task automatic check_unit(input int u, input logic rn,
                              input logic v0, input logic [W-1:0] d0,
                              input logic v1, input logic [W-1:0] d1,
                              input logic r0, input logic r1,
                              input logic so, input logic sv, input logic ss,
                              input logic sl, input logic gid, input logic bsy);
        int   k;
        logic e_sv, e_so, e_ss, e_sl, e_bsy, idle, e_r0, e_r1;
        string p;
        p = (u == 0) ? "a_" : "b_";
        if (!rn) model_reset(u);
        k     = cyc - m_acc[u];
        e_sv  = rn && (m_has[u] != 0) && k >= 1 && k <= W;
        e_so  = e_sv ? m_word[u][W-k] : 1'b0;
        e_ss  = e_sv && k == 1;
        e_sl  = e_sv && k == W;
        e_bsy = rn && (m_has[u] != 0) && k >= 1 && k <= W + gapv[u];
        idle  = rn && ((m_has[u] == 0) || k > W + gapv[u]);
        e_r0  = idle && v0 && (!v1 || m_ptr[u] == 1);
        e_r1  = idle && v1 && (!v0 || m_ptr[u] == 0);
        chk1({p, "s_valid"},  sv,  e_sv);
        chk1({p, "s_out"},    so,  e_so);
        chk1({p, "s_start"},  ss,  e_ss);
        chk1({p, "s_last"},   sl,  e_sl);
        chk1({p, "busy"},     bsy, e_bsy);
        chk1({p, "grant_id"}, gid, m_grant[u]);
        chk1({p, "req0_ready"}, r0, e_r0);
        chk1({p, "req1_ready"}, r1, e_r1);
        chk1({p, "ready_excl"}, r0 & r1, 1'b0);
        acc_now[u] = 1'b0;
        if (e_r0 || e_r1) begin
            m_has[u]   = 1;
            m_acc[u]   = cyc;
            m_word[u]  = e_r0 ? d0 : d1;
            m_grant[u] = e_r1;
            m_ptr[u]   = e_r1 ? 1 : 0;
            acc_now[u] = 1'b1;
            if (u == 0) begin
                qc_a.push_back(cyc);
                qg_a.push_back(e_r1 ? 1 : 0);
            end else begin
                qc_b.push_back(cyc);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_unit(0, rst_a_n, bus_a.req0_valid, bus_a.req0_data,
                   bus_a.req1_valid, bus_a.req1_data, bus_a.req0_ready,
                   bus_a.req1_ready, bus_a.s_out, bus_a.s_valid, bus_a.s_start,
                   bus_a.s_last, bus_a.grant_id, bus_a.busy);
        check_unit(1, rst_b_n, bus_b.req0_valid, bus_b.req0_data,
                   bus_b.req1_valid, bus_b.req1_data, bus_b.req0_ready,
                   bus_b.req1_ready, bus_b.s_out, bus_b.s_valid, bus_b.s_start,
                   bus_b.s_last, bus_b.grant_id, bus_b.busy);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_a(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1);
        bus_a.req0_valid = v0;
        bus_a.req0_data  = d0;
        bus_a.req1_valid = v1;
        bus_a.req1_data  = d1;
    endtask

    task automatic pulse_reset_a();
        rst_a_n = 1'b0;
        step();
        rst_a_n = 1'b1;
    endtask

    task automatic spacing_a(input int n, input int period);
        chki("a_acc_count", qc_a.size(), n);
        for (int i = 1; i < qc_a.size(); i++)
            chki("a_acc_spacing", qc_a[i] - qc_a[i-1], period);
    endtask

    initial begin
        gapv[0] = 1;
        gapv[1] = 0;
        model_reset(0);
        model_reset(1);
        set_a(1'b0, '0, 1'b0, '0);
        bus_b.req0_valid = 1'b0;
        bus_b.req0_data  = '0;
        bus_b.req1_valid = 1'b0;
        bus_b.req1_data  = '0;

        // Reset state
        steps(3);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        steps(2);

        // 1: single word from requester 0
        set_a(1'b1, 4'b1011, 1'b0, '0);
        step();
        set_a(1'b0, 4'b1011, 1'b0, '0);
        steps(8);

        // 2: both valid at once from a fresh pointer
        pulse_reset_a();
        qc_a.delete();
        qg_a.delete();
        set_a(1'b1, 4'hA, 1'b1, 4'h5);
        for (int i = 0; i < 14; i++) begin
            step();
            if (acc_now[0]) begin
                if (m_grant[0]) bus_a.req1_valid = 1'b0;
                else            bus_a.req0_valid = 1'b0;
            end
        end
        spacing_a(2, 6);
        if (qg_a.size() == 2) begin
            chki("t2_first_grant", qg_a[0], 0);
            chki("t2_second_grant", qg_a[1], 1);
        end

        // 3: continuous contention with fresh data after each accept
        qc_a.delete();
        qg_a.delete();
        set_a(1'b1, 4'($urandom), 1'b1, 4'($urandom));
        for (int i = 0; i < 24; i++) begin
            step();
            if (acc_now[0]) begin
                if (m_grant[0]) bus_a.req1_data = 4'($urandom);
                else            bus_a.req0_data = 4'($urandom);
            end
        end
        set_a(1'b0, '0, 1'b0, '0);
        steps(8);
        spacing_a(4, 6);
        for (int i = 0; i < qg_a.size(); i++)
            chki("t3_grant_seq", qg_a[i], i % 2);

        // 4: requester 1 back-to-back, data disturbed after acceptance
        qc_a.delete();
        qg_a.delete();
        set_a(1'b0, '0, 1'b1, 4'hF);
        for (int i = 0; i < 14; i++) begin
            step();
            if (acc_now[0]) begin
                if (qc_a.size() == 1) bus_a.req1_data = 4'h0;
                else begin
                    bus_a.req1_valid = 1'b0;
                    bus_a.req1_data  = 4'($urandom);
                end
            end
        end
        spacing_a(2, 6);

        // Random traffic on both units, valids may drop before acceptance
        for (int i = 0; i < 80; i++) begin
            set_a(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
            bus_b.req0_valid = 1'($urandom);
            bus_b.req0_data  = 4'($urandom);
            bus_b.req1_valid = 1'($urandom);
            bus_b.req1_data  = 4'($urandom);
            step();
        end
        set_a(1'b0, '0, 1'b0, '0);
        bus_b.req0_valid = 1'b0;
        bus_b.req1_valid = 1'b0;
        steps(8);

        // 5: reset in the middle of a requester-1 frame
        qc_a.delete();
        qg_a.delete();
        set_a(1'b0, '0, 1'b1, 4'($urandom));
        for (int i = 0; i < 10 && qc_a.size() == 0; i++) step();
        chki("t5_req1_accepted", qc_a.size(), 1);
        set_a(1'b0, '0, 1'b0, '0);
        steps(2);
        rst_a_n = 1'b0;
        #1;
        chk1("t5_async_s_valid", bus_a.s_valid, 1'b0);
        chk1("t5_async_s_out",   bus_a.s_out,   1'b0);
        chk1("t5_async_s_last",  bus_a.s_last,  1'b0);
        chk1("t5_async_busy",    bus_a.busy,    1'b0);
        chk1("t5_async_grant",   bus_a.grant_id, 1'b0);
        set_a(1'b1, 4'($urandom), 1'b1, 4'($urandom));
        steps(2);
        rst_a_n = 1'b1;
        qg_a.delete();
        step();
        set_a(1'b0, '0, 1'b0, '0);
        chki("t5_grant_after_reset", (qg_a.size() == 1) ? qg_a[0] : -1, 0);
        steps(8);

        // 6: GAP=0 streaming on unit b
        qc_b.delete();
        bus_b.req0_valid = 1'b1;
        bus_b.req0_data  = 4'($urandom);
        for (int i = 0; i < 22; i++) begin
            step();
            if (acc_now[1]) bus_b.req0_data = 4'($urandom);
        end
        bus_b.req0_valid = 1'b0;
        steps(6);
        chki("b_acc_count", qc_b.size(), 5);
        for (int i = 1; i < qc_b.size(); i++)
            chki("b_acc_spacing", qc_b[i] - qc_b[i-1], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
